leve_inst_queue: RTL and testbench
==================================

LEVE_INST_QUEUE -- requirements
Module: LEVE_INST_QUEUE

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of instruction entries (power of two, at least 4).
REQ-002 SHALL have parameter OUTST, default 2, number of outstanding fetch bursts tracked.
REQ-003 SHALL have port CLK, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RSTn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port AR_FIRE, input, 1, fetch address handshake (ARVALID & ARREADY) seen on the instruction AXI read channel.
REQ-006 SHALL have port AR_ADDR, input, 32, start address of the burst, valid with AR_FIRE.
REQ-007 SHALL have port AR_STALL, output, 1, high when the address tracker is full; the fetch stage must not issue another burst.
REQ-008 SHALL have port RVALID, input, 1, AXI read data valid.
REQ-009 SHALL have port RREADY, output, 1, AXI read data ready.
REQ-010 SHALL have port RDATA, input, 32, one instruction per beat.
REQ-011 SHALL have port RRESP, input, 2, AXI response.
REQ-012 SHALL have port RLAST, input, 1, last beat of the burst.
REQ-013 SHALL have port FLUSH, input, 1, redirect: discard queued and in-flight instructions.
REQ-014 SHALL have port OUT_VALID, output, 1, instruction available to decode.
REQ-015 SHALL have port OUT_READY, input, 1, decode accepts.
REQ-016 SHALL have port OUT_PC, output, 32, address of the presented instruction.
REQ-017 SHALL have port OUT_INST, output, 32, presented instruction.
REQ-018 SHALL have port OUT_ERR, output, 1, fetch bus error for the presented instruction.

Function
REQ-019 SHALL record {AR_ADDR, stale=0} in an OUTST-entry address FIFO on AR_FIRE.
REQ-020 SHALL drive AR_STALL = (address FIFO count == OUTST), combinationally from registered state.
REQ-021 SHALL treat every burst as a WRAP burst of 4 beats of 4 bytes: the address of beat i is {A[31:4], (A[3:2]+i) mod 4, 2'b00}, where A is the head address entry and i is a 2-bit beat counter.
REQ-022 SHALL drive RREADY=0 when the address FIFO is empty.
REQ-023 SHALL drive RREADY=1 when the head address entry is stale, so stale beats drain unconditionally.
REQ-024 Otherwise, SHALL drive RREADY = (queue count != DEPTH); RREADY is not relieved by a same-cycle pop.
REQ-025 On an accepted non-stale beat (RVALID & RREADY), SHALL push {beat address, RDATA, RRESP != 2'b00} into the queue; the entry becomes visible on OUT_* in the next cycle (latency 1).
REQ-026 SHALL discard accepted stale beats without writing the queue.
REQ-027 SHALL increment the beat counter on each accepted beat.
REQ-028 On an accepted beat with RLAST=1, SHALL pop the address FIFO and clear the beat counter, regardless of the beat count; the same rule applies to stale bursts.
REQ-029 SHALL drive OUT_VALID = (queue count != 0), with OUT_PC, OUT_INST and OUT_ERR taken from the head entry.
REQ-030 SHALL pop the head entry on OUT_VALID & OUT_READY.
REQ-031 SHALL support simultaneous push and pop, leaving the count unchanged.
REQ-032 SHALL wrap the queue read and write pointers modulo DEPTH.
REQ-033 On FLUSH=1, SHALL set the queue count to 0 and the pointers to 0 next cycle.
REQ-034 On FLUSH=1, SHALL mark every existing address entry stale.
REQ-035 On FLUSH=1, SHALL drop a same-cycle R beat and a same-cycle pop.
REQ-036 SHALL give an AR_FIRE that coincides with FLUSH a non-stale entry, because it belongs to the redirected stream.
REQ-037 SHALL, when FLUSH coincides with the RLAST beat of the head entry, pop that entry and mark the remaining entries stale.
REQ-038 SHALL keep OUT_* stable while OUT_VALID=1 and OUT_READY=0, unless FLUSH is asserted.

Reset
REQ-039 While RSTn=0, SHALL asynchronously clear queue count, pointers, address FIFO, stale bits and beat counter.
REQ-040 While RSTn=0, SHALL hold OUT_VALID=0, RREADY=0 and AR_STALL=0.
REQ-041 SHALL clear OUT_PC, OUT_INST and OUT_ERR to 0 on reset.
REQ-042 SHALL make a reset asserted mid-burst abandon the burst; after RSTn rises, no address entry exists, so leftover beats see RREADY=0.

Verification
REQ-043 Bench SHALL cover the wrap burst: AR_ADDR=0x0000_1008, RDATA 0xA0..0xA3 -> OUT_PC sequence 0x1008, 0x100C, 0x1000, 0x1004 with matching INST, each OUT_VALID one cycle after its beat.
REQ-044 Bench SHALL cover backpressure: DEPTH=8, OUT_READY=0, two bursts of 4 beats -> RREADY drops after the 8th beat, AR_STALL=1 while 2 bursts are outstanding, and no entry is lost or reordered when OUT_READY is released.
REQ-045 Bench SHALL cover flush mid-burst: FLUSH after beat 2 of burst 0x2000, with a new AR 0x3000 in the same cycle -> queue empty next cycle, beats 3-4 of 0x2000 are accepted but discarded, and the first OUT_PC is 0x3000.
REQ-046 Bench SHALL cover a bus error: RRESP=2'b10 on beat 1 of burst 0x4000 -> entry 0x4004 presented with OUT_ERR=1 and the other entries with OUT_ERR=0.
REQ-047 Bench SHALL cover simultaneous push/pop at full (count=8, OUT_READY=1, RVALID=1) -> beat not accepted (RREADY=0), count 7 next cycle, and the beat accepted the following cycle.
REQ-048 Bench SHALL cover reset mid-burst: RSTn low after beat 1 -> OUT_VALID=0 and RREADY=0 immediately, and both stay 0 after release until a new AR_FIRE.

Source files
------------

// File: rtl/leve_inst_queue_if.sv
// Instruction-fetch queue bus: AXI read-channel tap, flush and decode handshake.
// The queue sits on the slave modport; the fetch/decode side on master.
interface leve_inst_queue_if;
    logic        AR_FIRE;
    logic [31:0] AR_ADDR;
    logic        AR_STALL;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_PC;
    logic [31:0] OUT_INST;
    logic        OUT_ERR;

    modport slave (
        input  AR_FIRE, AR_ADDR, RVALID, RDATA, RRESP, RLAST,
        input  FLUSH, OUT_READY,
        output AR_STALL, RREADY, OUT_VALID, OUT_PC, OUT_INST, OUT_ERR
    );

    modport master (
        output AR_FIRE, AR_ADDR, RVALID, RDATA, RRESP, RLAST,
        output FLUSH, OUT_READY,
        input  AR_STALL, RREADY, OUT_VALID, OUT_PC, OUT_INST, OUT_ERR
    );
endinterface

// File: rtl/leve_inst_queue.sv
// Instruction queue fed by 4-beat WRAP fetch bursts, with outstanding
// burst tracking and flush that drains stale in-flight beats.
module leve_inst_queue #(
    parameter int DEPTH = 8,
    parameter int OUTST = 2
) (
    input logic CLK,
    input logic RSTn,
    leve_inst_queue_if.slave bus
);

    localparam int QW = $clog2(DEPTH);
    localparam int AW = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int CW = $clog2(OUTST + 1);

    logic [31:0]      a_addr [OUTST];
    logic [OUTST-1:0] a_stale;
    logic [AW-1:0]    a_rd;
    logic [AW-1:0]    a_wr;
    logic [CW-1:0]    a_cnt;
    logic [1:0]       beat;

    logic [31:0]      q_pc   [DEPTH];
    logic [31:0]      q_inst [DEPTH];
    logic [DEPTH-1:0] q_err;
    logic [QW-1:0]    q_rd;
    logic [QW-1:0]    q_wr;
    logic [QW:0]      q_cnt;

    logic        a_full;
    logic        a_empty;
    logic [31:0] head_addr;
    logic        head_stale;
    logic [1:0]  beat_sel;
    logic [31:0] beat_pc;
    logic        rready;
    logic        r_acc;
    logic        r_last;
    logic        q_push;
    logic        q_pop;
    logic        a_push;
    logic        out_valid;

    function automatic logic [AW-1:0] a_next(input logic [AW-1:0] p);
        return (p == AW'(OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        a_empty    = (a_cnt == '0);
        a_full     = (a_cnt == CW'(OUTST));
        head_addr  = a_addr[a_rd];
        head_stale = a_stale[a_rd];
        beat_sel   = head_addr[3:2] + beat;
        beat_pc    = {head_addr[31:4], beat_sel, 2'b00};
        // Stale bursts always drain; live ones wait for queue space.
        rready     = !a_empty &&
                     (head_stale || (q_cnt != (QW+1)'(DEPTH)));
        r_acc      = bus.RVALID & rready;
        r_last     = r_acc & bus.RLAST;
        q_push     = r_acc & ~head_stale & ~bus.FLUSH;
        out_valid  = (q_cnt != '0);
        q_pop      = out_valid & bus.OUT_READY & ~bus.FLUSH;
        a_push     = bus.AR_FIRE & (~a_full | r_last);
    end

    assign bus.AR_STALL  = a_full;
    assign bus.RREADY    = rready;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_PC    = q_pc[q_rd];
    assign bus.OUT_INST  = q_inst[q_rd];
    assign bus.OUT_ERR   = q_err[q_rd];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < OUTST; i++) a_addr[i] <= '0;
            a_stale <= '0;
            a_rd    <= '0;
            a_wr    <= '0;
            a_cnt   <= '0;
            beat    <= '0;
        end else begin
            if (r_acc) beat <= r_last ? 2'd0 : beat + 2'd1;
            if (r_last) a_rd <= a_next(a_rd);
            if (bus.FLUSH) a_stale <= '1;
            // A burst issued with the flush belongs to the new stream.
            if (a_push) begin
                a_addr[a_wr]  <= bus.AR_ADDR;
                a_stale[a_wr] <= 1'b0;
                a_wr          <= a_next(a_wr);
            end
            a_cnt <= a_cnt + CW'(a_push) - CW'(r_last);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
            q_err <= '0;
            q_rd  <= '0;
            q_wr  <= '0;
            q_cnt <= '0;
        end else if (bus.FLUSH) begin
            q_rd  <= '0;
            q_wr  <= '0;
            q_cnt <= '0;
        end else begin
            if (q_push) begin
                q_pc[q_wr]   <= beat_pc;
                q_inst[q_wr] <= bus.RDATA;
                q_err[q_wr]  <= (bus.RRESP != 2'b00);
                q_wr         <= q_wr + 1'b1;
            end
            if (q_pop) q_rd <= q_rd + 1'b1;
            q_cnt <= q_cnt + (QW+1)'(q_push) - (QW+1)'(q_pop);
        end
    end

endmodule

// File: tb/tb_leve_inst_queue.sv
// Bench for leve_inst_queue: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_leve_inst_queue;

    localparam int DEPTH = 8;
    localparam int OUTST = 2;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    leve_inst_queue_if bus ();

    leve_inst_queue #(.DEPTH(DEPTH), .OUTST(OUTST)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } ar_t;

    ent_t        mq[$];
    ar_t         ma[$];
    int          mbeat = 0;
    logic [31:0] sq[$];
    int          sbeat = 0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          err_beat = -1;
    bit          rnd_data = 0;
    bit          rnd_resp = 0;
    logic [31:0] dbase = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        ma.delete();
        mbeat = 0;
    endtask

    // One clock: drive, check against the model, update the model.
    task automatic tick(input bit fire, input logic [31:0] a, input bit rv,
                        input bit ordy, input bit fl);
        bit          mr;
        bit          acc;
        ent_t        e;
        logic [31:0] base;
        logic [31:0] off;
        bus.AR_FIRE   = fire;
        bus.AR_ADDR   = a;
        bus.FLUSH     = fl;
        bus.OUT_READY = ordy;
        bus.RVALID    = rv && (sq.size() != 0);
        bus.RLAST     = (sbeat == 3);
        bus.RDATA     = rnd_data ? $urandom : dbase + 32'(sbeat);
        bus.RRESP     = 2'b00;
        if (sq.size() != 0 && sq[0] == err_addr && sbeat == err_beat)
            bus.RRESP = 2'b10;
        else if (rnd_resp && $urandom_range(0, 7) == 0)
            bus.RRESP = 2'($urandom_range(1, 3));
        #1;
        mr = (ma.size() != 0) && (ma[0].stale || mq.size() != DEPTH);
        chk1("rready", bus.RREADY, mr);
        chk1("ar_stall", bus.AR_STALL, ma.size() == OUTST);
        chk1("out_valid", bus.OUT_VALID, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_pc", bus.OUT_PC, mq[0].pc);
            chk("out_inst", bus.OUT_INST, mq[0].inst);
            chk1("out_err", bus.OUT_ERR, mq[0].err);
        end
        acc = bus.RVALID && mr;
        if (mq.size() != 0 && ordy && !fl) void'(mq.pop_front());
        if (acc) begin
            if (!ma[0].stale && !fl) begin
                base   = ma[0].addr & 32'hFFFF_FFF0;
                off    = (((ma[0].addr >> 2) + 32'(mbeat)) % 32'd4) * 32'd4;
                e.pc   = base + off;
                e.inst = bus.RDATA;
                e.err  = (bus.RRESP != 2'b00);
                mq.push_back(e);
            end
            mbeat++;
            if (bus.RLAST) begin
                void'(ma.pop_front());
                mbeat = 0;
            end
        end
        if (fl) begin
            mq.delete();
            foreach (ma[i]) ma[i].stale = 1'b1;
        end
        if (fire) begin
            ma.push_back('{addr: a, stale: 1'b0});
            sq.push_back(a);
        end
        if (acc) begin
            if (sbeat == 3) begin
                void'(sq.pop_front());
                sbeat = 0;
            end else begin
                sbeat++;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((mq.size() != 0 || ma.size() != 0) && n < 60) begin
            tick(0, '0, 1, 1, 0);
            n++;
        end
        chk({tag, "_drained"}, 32'(mq.size() + ma.size()), 32'd0);
    endtask

    logic [31:0] wrap_pc [4] = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
    logic [31:0] err_pc  [4] = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
    logic        err_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        bus.AR_FIRE   = 0;
        bus.AR_ADDR   = '0;
        bus.RVALID    = 0;
        bus.RDATA     = '0;
        bus.RRESP     = '0;
        bus.RLAST     = 0;
        bus.FLUSH     = 0;
        bus.OUT_READY = 0;
        repeat (2) @(negedge CLK);
        #1;
        chk1("rst_out_valid", bus.OUT_VALID, 1'b0);
        chk1("rst_rready", bus.RREADY, 1'b0);
        chk1("rst_ar_stall", bus.AR_STALL, 1'b0);
        chk("rst_out_pc", bus.OUT_PC, 32'h0);
        chk("rst_out_inst", bus.OUT_INST, 32'h0);
        chk1("rst_out_err", bus.OUT_ERR, 1'b0);
        @(negedge CLK);
        RSTn = 1'b1;

        // Wrap burst, each entry visible one cycle after its beat
        dbase = 32'hA0;
        tick(1, 32'h1008, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, '0, 1, 1, 0);
            chk1("wrap_valid", bus.OUT_VALID, 1'b1);
            chk("wrap_pc", bus.OUT_PC, wrap_pc[i]);
            chk("wrap_inst", bus.OUT_INST, 32'hA0 + 32'(i));
        end
        tick(0, '0, 0, 1, 0);
        chk1("wrap_empty", bus.OUT_VALID, 1'b0);

        // Backpressure: two bursts fill the queue
        dbase = 32'hB0;
        tick(1, 32'h5000, 0, 0, 0);
        tick(1, 32'h6004, 0, 0, 0);
        chk1("bp_stall", bus.AR_STALL, 1'b1);
        for (int i = 0; i < 8; i++) tick(0, '0, 1, 0, 0);
        chk1("bp_rready_drop", bus.RREADY, 1'b0);
        chk("bp_head_pc", bus.OUT_PC, 32'h5000);

        // Full queue, push and pop offered together
        tick(1, 32'h8000, 0, 0, 0);
        chk1("full_rready", bus.RREADY, 1'b0);
        tick(0, '0, 1, 1, 0);
        chk1("full_rready_next", bus.RREADY, 1'b1);
        chk("full_head_pc", bus.OUT_PC, 32'h5004);
        tick(0, '0, 1, 1, 0);
        drain("bp");

        // Flush after beat 2 with a new burst issued in the same cycle
        dbase = 32'hC0;
        tick(1, 32'h2000, 0, 0, 0);
        tick(0, '0, 1, 0, 0);
        tick(0, '0, 1, 0, 0);
        tick(1, 32'h3000, 0, 0, 1);
        chk1("flush_empty", bus.OUT_VALID, 1'b0);
        tick(0, '0, 1, 0, 0);
        tick(0, '0, 1, 0, 0);
        chk1("flush_discard", bus.OUT_VALID, 1'b0);
        tick(0, '0, 1, 0, 0);
        chk1("flush_new_valid", bus.OUT_VALID, 1'b1);
        chk("flush_first_pc", bus.OUT_PC, 32'h3000);
        drain("flush");

        // Bus error on beat 1
        dbase    = 32'hD0;
        err_addr = 32'h4000;
        err_beat = 1;
        tick(1, 32'h4000, 0, 0, 0);
        repeat (4) tick(0, '0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("err_pc", bus.OUT_PC, err_pc[i]);
            chk1("err_flag", bus.OUT_ERR, err_exp[i]);
            tick(0, '0, 0, 1, 0);
        end
        chk1("err_empty", bus.OUT_VALID, 1'b0);
        err_addr = 32'hFFFF_FFFF;
        err_beat = -1;

        // Reset in the middle of a burst
        dbase = 32'hE0;
        tick(1, 32'h7000, 0, 0, 0);
        tick(0, '0, 1, 0, 0);
        #2 RSTn = 1'b0;
        #1;
        chk1("mid_rst_valid", bus.OUT_VALID, 1'b0);
        chk1("mid_rst_rready", bus.RREADY, 1'b0);
        chk1("mid_rst_stall", bus.AR_STALL, 1'b0);
        model_clear();
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) tick(0, '0, 1, 1, 0);
        chk1("post_rst_rready", bus.RREADY, 1'b0);
        chk1("post_rst_valid", bus.OUT_VALID, 1'b0);
        sq.delete();
        sbeat = 0;
        tick(1, 32'h7100, 0, 1, 0);
        chk1("post_rst_new_ar", bus.RREADY, 1'b1);
        drain("rst");

        // Random traffic
        rnd_data = 1;
        rnd_resp = 1;
        for (int i = 0; i < 800; i++) begin
            tick((ma.size() < OUTST) && ($urandom_range(0, 2) == 0),
                 $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 39) == 0);
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
